riscv_core_compressor_tree_pipe: RTL and testbench

//  Pipelined, parametrised multi-operand reduction tree for the M-extension multiplier.

---
 rtl/riscv_core_compressor_tree_pipe.sv | 191 +++++++++++++++++++
 tb/tb_riscv_core_compressor_tree_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_compressor_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_compressor_tree_pipe
// Brief    : Pipelined multi-operand reduction tree built from word-level 4:2
//            compressors. One register stage follows every tree level. The
//            pipeline has a valid/ready handshake with backpressure, a flush
//            input and a sideband tag.
// Option   : RISCV_CORE_CT_FINAL_ADD_EN adds a carry-propagate add stage after
//            the tree. The sum output then carries the final result and the
//            carry output is driven to zero.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_compressor_tree_pipe #(
    parameter int OP_W         = 128,
    parameter int NUM_OPERANDS = 8,
    parameter int TAG_W        = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_compressor_tree_valid,
    output logic                         o_compressor_tree_ready,
    input  logic [NUM_OPERANDS*OP_W-1:0] i_compressor_tree_operands,
    input  logic [TAG_W-1:0]             i_compressor_tree_tag,
    input  logic                         i_compressor_tree_flush,
    output logic                         o_compressor_tree_valid,
    input  logic                         i_compressor_tree_ready,
    output logic [OP_W-1:0]              o_compressor_tree_sum,
    output logic [OP_W-1:0]              o_compressor_tree_carry,
    output logic [TAG_W-1:0]             o_compressor_tree_tag
);

    localparam int LEVELS = $clog2(NUM_OPERANDS) - 1;
`ifdef RISCV_CORE_CT_FINAL_ADD_EN
    localparam int NSTG = LEVELS + 1;
`else
    localparam int NSTG = LEVELS;
`endif
    // Every tree stage register packed back to back: stage s starts at word
    // NUM_OPERANDS - (NUM_OPERANDS >> s) and holds NUM_OPERANDS >> (s+1) words.
    localparam int TREE_W   = OP_W * (NUM_OPERANDS - 2);
    localparam int LAST_OFF = OP_W * (NUM_OPERANDS - 4);

    if (!(NUM_OPERANDS == 4 || NUM_OPERANDS == 8 ||
          NUM_OPERANDS == 16 || NUM_OPERANDS == 32)) begin : g_bad_num_operands
        $error("riscv_core_compressor_tree_pipe: NUM_OPERANDS must be 4, 8, 16 or 32");
    end

    // Word-level 4:2 compressor as two cascaded carry-save adders; returns
    // {carry, sum} with the carry already shifted into its weight position.
    function automatic logic [2*OP_W-1:0] f_compress_4to2(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b,
        input logic [OP_W-1:0] c,
        input logic [OP_W-1:0] d
    );
        logic [OP_W-1:0] s1, c1, s2, c2;
        s1 = a ^ b ^ c;
        c1 = ((a & b) | (a & c) | (b & c)) << 1;
        s2 = s1 ^ c1 ^ d;
        c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
        return {c2, s2};
    endfunction

    logic [NSTG-1:0]  valid_q, valid_d;
    logic [NSTG-1:0]  adv, load;
    logic             accept;
    logic [TAG_W-1:0] tag_q [NSTG];
    logic [TAG_W-1:0] tag_d [NSTG];
    wire  [TREE_W-1:0] w_tree_q;
    wire  [OP_W-1:0]   w_tree_sum   = w_tree_q[LAST_OFF +: OP_W];
    wire  [OP_W-1:0]   w_tree_carry = w_tree_q[LAST_OFF + OP_W +: OP_W];

    // Handshake: advance chain runs from the output stage back to the input.
    always_comb begin
        adv  = '0;
        load = '0;
        adv[NSTG-1] = valid_q[NSTG-1] & i_compressor_tree_ready;
        for (int s = NSTG - 2; s >= 0; s--) begin
            adv[s] = valid_q[s] & (~valid_q[s+1] | adv[s+1]);
        end
        o_compressor_tree_ready = ~valid_q[0] | adv[0];
        accept  = i_compressor_tree_valid & o_compressor_tree_ready;
        load[0] = accept;
        for (int s = 1; s < NSTG; s++) begin
            load[s] = adv[s-1];
        end
        for (int s = 0; s < NSTG; s++) begin
            valid_d[s] = i_compressor_tree_flush ? 1'b0
                       : (load[s] | (valid_q[s] & ~adv[s]));
        end
    end

    // Tag pipeline follows the same load enables as the data.
    always_comb begin
        for (int s = 0; s < NSTG; s++) begin
            tag_d[s] = tag_q[s];
        end
        if (load[0]) begin
            tag_d[0] = i_compressor_tree_tag;
        end
        for (int s = 1; s < NSTG; s++) begin
            if (load[s]) begin
                tag_d[s] = tag_q[s-1];
            end
        end
    end

    // Valid and tag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        localparam int N_IN    = NUM_OPERANDS >> s;
        localparam int W_IN    = OP_W * N_IN;
        localparam int W_OUT   = W_IN / 2;
        localparam int OUT_OFF = OP_W * (NUM_OPERANDS - N_IN);
        localparam int IN_OFF  = OP_W * (NUM_OPERANDS - 2 * N_IN);

        wire  [W_IN-1:0]  w_in;
        wire  [W_OUT-1:0] w_out;
        logic [W_OUT-1:0] data_q, data_d;

        if (s == 0) begin : g_src_ops
            assign w_in = i_compressor_tree_operands;
        end else begin : g_src_prev
            assign w_in = w_tree_q[IN_OFF +: W_IN];
        end

        for (genvar g = 0; g < N_IN / 4; g++) begin : g_grp
            assign w_out[g*2*OP_W +: 2*OP_W] = f_compress_4to2(
                w_in[(4*g+0)*OP_W +: OP_W], w_in[(4*g+1)*OP_W +: OP_W],
                w_in[(4*g+2)*OP_W +: OP_W], w_in[(4*g+3)*OP_W +: OP_W]);
        end

        // Stage data loads only when an entry moves into this stage.
        always_comb begin
            data_d = load[s] ? w_out : data_q;
        end

        // Stage data register.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign w_tree_q[OUT_OFF +: W_OUT] = data_q;
    end

`ifdef RISCV_CORE_CT_FINAL_ADD_EN
    logic [OP_W-1:0] fsum_q, fsum_d;

    // Carry-propagate add of the last redundant pair, loaded on advance.
    always_comb begin
        fsum_d = load[NSTG-1] ? (w_tree_sum + w_tree_carry) : fsum_q;
    end

    // Final-sum register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsum_q <= '0;
        end else begin
            fsum_q <= fsum_d;
        end
    end

    assign o_compressor_tree_sum   = fsum_q;
    assign o_compressor_tree_carry = '0;
`else
    assign o_compressor_tree_sum   = w_tree_sum;
    assign o_compressor_tree_carry = w_tree_carry;
`endif

    assign o_compressor_tree_valid = valid_q[NSTG-1];
    assign o_compressor_tree_tag   = tag_q[NSTG-1];

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_compressor_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_compressor_tree_pipe
// Brief    : Self-checking bench for the pipelined compressor tree
//            (OP_W=8, NUM_OPERANDS=8). Expected results are plain byte sums
//            of the operands, queued in order and popped on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_compressor_tree_pipe;

`ifdef RISCV_CORE_CT_FINAL_ADD_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ops;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic [7:0]  out_carry;
    logic [4:0]  out_tag;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int first_v = -1;
    int last_v  = -1;
    int vcnt    = 0;
    logic [7:0] q_sum [$];
    logic [4:0] q_tag [$];

    riscv_core_compressor_tree_pipe #(
        .OP_W(8), .NUM_OPERANDS(8), .TAG_W(5)
    ) dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_compressor_tree_valid    (in_valid),
        .o_compressor_tree_ready    (in_ready),
        .i_compressor_tree_operands (ops),
        .i_compressor_tree_tag      (in_tag),
        .i_compressor_tree_flush    (flush),
        .o_compressor_tree_valid    (out_valid),
        .i_compressor_tree_ready    (out_ready),
        .o_compressor_tree_sum      (out_sum),
        .o_compressor_tree_carry    (out_carry),
        .o_compressor_tree_tag      (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_sum(input logic [63:0] v);
        int acc = 0;
        for (int k = 0; k < 8; k++) acc += int'(v[k*8 +: 8]);
        return 8'(acc % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, update the model,
    // then return just after the next rising edge.
    task automatic tick();
        logic [7:0] rs;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
            chk("out_expected", 32'(q_sum.size() != 0), 32'd1);
            if (q_sum.size() != 0) begin
                rs = out_sum + out_carry;
                chk("result", 32'(rs), 32'(q_sum.pop_front()));
                chk("result_tag", 32'(out_tag), 32'(q_tag.pop_front()));
`ifdef RISCV_CORE_CT_FINAL_ADD_EN
                chk("result_carry0", 32'(out_carry), 32'd0);
`endif
            end
        end
        if (flush) begin
            q_sum.delete();
            q_tag.delete();
        end else if (in_valid && in_ready && rst_n) begin
            q_sum.push_back(ref_sum(ops));
            q_tag.push_back(in_tag);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4*LAT + 8 && q_sum.size() != 0; i++) tick();
        chk("drain_empty", 32'(q_sum.size()), 32'd0);
    endtask

    // Single op with downstream ready: checks exact latency and the result.
    task automatic run_single(input logic [63:0] o, input logic [4:0] t,
                              input logic [7:0] exp, input string name);
        logic [7:0] rs;
        ops = o; in_tag = t; in_valid = 1'b1;
        #1 chk({name, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            #1 chk({name, "_early"}, 32'(out_valid), 32'd0);
            tick();
        end
        #1 chk({name, "_valid"}, 32'(out_valid), 32'd1);
        rs = out_sum + out_carry;
        chk({name, "_sum"}, 32'(rs), 32'(exp));
        chk({name, "_tag"}, 32'(out_tag), 32'(t));
`ifdef RISCV_CORE_CT_FINAL_ADD_EN
        chk({name, "_carry0"}, 32'(out_carry), 32'd0);
`endif
        tick();
    endtask

    initial begin
        logic [7:0] rs;
        rst_n = 1'b1; in_valid = 1'b0; ops = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All operands 0xFF: 8*255 mod 256 = 0xF8
        run_single({8{8'hFF}}, 5'd3, 8'hF8, "t1");

        // Back-to-back random ops with no backpressure
        first_v = -1; vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            ops = {$urandom, $urandom}; in_tag = 5'(i); in_valid = 1'b1;
            #1 chk("t2_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("t2_count", 32'(vcnt), 32'd10);
        chk("t2_consecutive", 32'(last_v - first_v + 1), 32'd10);

        // Fill under backpressure, hold, then release
        out_ready = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            ops = {$urandom, $urandom}; in_tag = 5'(16 + k); in_valid = 1'b1;
            #1 chk("t3_fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        ops = {$urandom, $urandom}; in_tag = 5'd31;
        #1 chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_full_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1 chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_ready", 32'(in_ready), 32'd0);
            rs = out_sum + out_carry;
            chk("t3_hold_sum", 32'(rs), 32'(q_sum[0]));
            chk("t3_hold_tag", 32'(out_tag), 32'(q_tag[0]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("t3_release_ready", 32'(in_ready), 32'd1);
        drain();

        // Flush with every stage occupied and a new input offered
        for (int k = 0; k < LAT; k++) begin
            ops = {$urandom, $urandom}; in_tag = 5'(8 + k); in_valid = 1'b1;
            tick();
        end
        ops = {$urandom, $urandom}; in_tag = 5'd30; flush = 1'b1; out_ready = 1'b0;
        #1 chk("t4_pre_valid", 32'(out_valid), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("t4_post_valid", 32'(out_valid), 32'd0);
        chk("t4_post_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            #1 chk("t4_no_result", 32'(out_valid), 32'd0);
        end

        // Random valid / backpressure mix
        for (int i = 0; i < 40; i++) begin
            ops = {$urandom, $urandom}; in_tag = 5'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 3; k++) begin
            ops = {$urandom, $urandom}; in_tag = 5'(k + 1); in_valid = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        chk("t5_sum", 32'(out_sum), 32'd0);
        chk("t5_carry", 32'(out_carry), 32'd0);
        chk("t5_tag", 32'(out_tag), 32'd0);
        in_valid = 1'b0;
        q_sum.delete();
        q_tag.delete();
        tick();
        rst_n = 1'b1;
        run_single(64'h0807060504030201, 5'd9, 8'h24, "t5_after");

        // 0x80 x8 wraps to zero
        run_single({8{8'h80}}, 5'd21, 8'h00, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
